// File: rtl/vga_fb_arbiter_if.sv
// Write-request and framebuffer-RAM bus for vga_fb_arbiter.
// DW is the pixel width: 24 for {r,g,b}, 1 for the mono build (VGA_FB_MONO_EN).
interface vga_fb_arbiter_if #(
  parameter int DW = 24
);
  logic          wr_valid;
  logic          wr_ready;
  logic [9:0]    wr_x;
  logic [8:0]    wr_y;
  logic [DW-1:0] wr_data;
  logic [18:0]   ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Arbiter side: accepts writes, owns the RAM port.
  modport slave (
    input  wr_valid, wr_x, wr_y, wr_data, ram_rdata,
    output wr_ready, ram_addr, ram_we, ram_wdata
  );

  // Requester/RAM side.
  modport master (
    output wr_valid, wr_x, wr_y, wr_data, ram_rdata,
    input  wr_ready, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display scan-out fetches run 3 pixels ahead
// of the beam and always own the RAM; buffered pixel writes drain in the gaps.
// Optional feature macro VGA_FB_MONO_EN: 1-bit pixels expanded to 8'h00/8'hFF.
module vga_fb_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int H_TOTAL    = 800,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        vga_clk,
  input  logic                        rst_n,
  input  logic                        timing_en,
  input  logic [9:0]                  hcount_in,
  input  logic [9:0]                  vcount_in,
  vga_fb_arbiter_if.slave             bus,
  output logic [7:0]                  px_r,
  output logic [7:0]                  px_g,
  output logic [7:0]                  px_b,
  output logic                        px_blank_n,
  output logic                        wr_oob,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
`ifdef VGA_FB_MONO_EN
  localparam int DATA_W = 1;
`else
  localparam int DATA_W = 24;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [10:0]   HT       = H_TOTAL[10:0];
  localparam logic [10:0]   HA       = H_ACTIVE[10:0];
  localparam logic [9:0]    VT       = V_TOTAL[9:0];
  localparam logic [9:0]    VA       = V_ACTIVE[9:0];
  localparam logic [AW:0]   DEPTH_L  = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [10:0]   LEAD     = 11'd3;

  // Expand a stored pixel to the 24-bit output colour.
  function automatic logic [23:0] to_rgb(input logic [DATA_W-1:0] d);
`ifdef VGA_FB_MONO_EN
    return {24{d[0]}};
`else
    return d;
`endif
  endfunction

  logic [10:0]       fx_sum;
  logic [10:0]       fx_p0;
  logic [9:0]        fy_p0;
  logic              disp_p0;
  logic              wslot_p0;
  logic [18:0]       disp_addr_p0;
  logic              in_range;
  logic              push;
  logic              store;
  logic [18:0]       wr_addr;
  logic              ready_en;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       level;
  logic [18:0]       fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              vld_p1;
  logic              vld_p2;

  // Stage p0: fetch coordinate LEAD pixels ahead of the beam, and slot choice.
  always_comb begin
    fx_sum  = {1'b0, hcount_in} + LEAD;
    fx_p0   = fx_sum;
    fy_p0   = vcount_in;
    if (fx_sum >= HT) begin
      fx_p0 = fx_sum - HT;
      fy_p0 = (vcount_in + 10'd1 >= VT) ? 10'd0 : vcount_in + 10'd1;
    end
    disp_p0      = timing_en && (fx_p0 < HA) && (fy_p0 < VA);
    wslot_p0     = !disp_p0 && (level != '0);
    disp_addr_p0 = 19'(fy_p0) * 19'(H_ACTIVE) + 19'(fx_p0);
  end

  // Out-of-range writes still complete the handshake but are never stored.
  assign in_range     = ({1'b0, bus.wr_x} < HA) && ({1'b0, bus.wr_y} < VA);
  assign bus.wr_ready = ready_en && (level != DEPTH_L);
  assign push         = bus.wr_valid && bus.wr_ready;
  assign store        = push && in_range;
  assign wr_addr      = 19'(bus.wr_y) * 19'(H_ACTIVE) + 19'(bus.wr_x);
  assign fifo_level   = level;

  // FIFO storage: payload only, no reset needed.
  always_ff @(posedge vga_clk) begin
    if (store) begin
      fifo_addr[wptr] <= wr_addr;
      fifo_data[wptr] <= bus.wr_data;
    end
  end

  // FIFO pointers, occupancy, ready gating and sticky out-of-range flag.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      ready_en <= 1'b0;
      wr_oob   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (store)              wptr   <= wptr + PTR_ONE;
      if (wslot_p0)           rptr   <= rptr + PTR_ONE;
      if (push && !in_range)  wr_oob <= 1'b1;
      case ({store, wslot_p0})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Stage p1: registered RAM port; display fetch wins, else drain FIFO head.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ram_addr  <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      vld_p1        <= 1'b0;
    end else begin
      vld_p1     <= disp_p0;
      bus.ram_we <= wslot_p0;
      if (disp_p0) begin
        bus.ram_addr <= disp_addr_p0;
      end else if (wslot_p0) begin
        bus.ram_addr  <= fifo_addr[rptr];
        bus.ram_wdata <= fifo_data[rptr];
      end
    end
  end

  // Stage p2: RAM read data arrives; track whether it is a visible pixel.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_p1;
  end

  // Stage p3: register the visible pixel or force black during blanking.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      {px_r, px_g, px_b} <= '0;
      px_blank_n         <= 1'b0;
    end else begin
      px_blank_n         <= vld_p2;
      {px_r, px_g, px_b} <= vld_p2 ? to_rgb(bus.ram_rdata) : 24'd0;
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: behavioural RAM, bench-driven timing counts,
// a write-queue/framebuffer reference model and directed plus random steps.
module tb_vga_fb_arbiter;
`ifdef VGA_FB_MONO_EN
  localparam int DW = 1;
`else
  localparam int DW = 24;
`endif
  localparam int HA = 640, HT = 800, VA = 480, VT = 525, DEPTH = 8;
  localparam int NPIX = HA * VA;

  logic       vga_clk = 1'b0;
  logic       rst_n, timing_en;
  logic [9:0] hcount, vcount;
  logic [7:0] px_r, px_g, px_b;
  logic       px_blank_n, wr_oob;
  logic [3:0] fifo_level;

  vga_fb_arbiter_if #(.DW(DW)) bus ();

  vga_fb_arbiter #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
                   .FIFO_DEPTH(DEPTH)) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .timing_en(timing_en),
    .hcount_in(hcount), .vcount_in(vcount), .bus(bus),
    .px_r(px_r), .px_g(px_g), .px_b(px_b), .px_blank_n(px_blank_n),
    .wr_oob(wr_oob), .fifo_level(fifo_level)
  );

  always #5 vga_clk = ~vga_clk;

  // Framebuffer RAM: preloaded with value = address, read-before-write.
  logic [DW-1:0] mem [NPIX];
  bit loaded = 1'b0;
  always @(posedge vga_clk) begin
    if (!loaded) begin
      for (int i = 0; i < NPIX; i++) mem[i] = DW'(i);
      loaded = 1'b1;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
    if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
  end

  typedef struct { int addr; logic [DW-1:0] data; } wr_t;
  wr_t           q[$];
  logic [DW-1:0] written [int];
  bit            model_oob = 1'b0;
  int            vectors = 0, miscompares = 0;
  int            steady = 0, wr_seen = 0, since_rst = 0;
  int            prev_h = 0, prev_v = 0, prev_qn = 0;
  bit            prev_en = 1'b0;
  logic [18:0]   last_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Fetch address for beam position (h,v), or -1 when no display fetch.
  function automatic int fetch_addr(int h, int v, bit en);
    int fx = h + 3, fy = v;
    if (fx >= HT) begin fx -= HT; fy = (v + 1) % VT; end
    return (en && fx < HA && fy < VA) ? fy * HA + fx : -1;
  endfunction

  function automatic logic [31:0] exp_rgb(int a);
    logic [DW-1:0] val;
    val = written.exists(a) ? written[a] : DW'(a);
`ifdef VGA_FB_MONO_EN
    return {8'd0, {24{val[0]}}};
`else
    return {8'd0, val};
`endif
  endfunction

  // Reference monitor: RAM-port slot rules, write order, FIFO level/ready, pixels.
  always @(negedge vga_clk) begin
    if (!rst_n) begin
      since_rst = 0; prev_qn = 0; last_addr = '0;
    end else begin
      since_rst++;
      if (since_rst >= 2) begin
        int fa;
        fa = fetch_addr(prev_h, prev_v, prev_en);
        if (fa >= 0) begin
          chk("disp_we", 32'(bus.ram_we), 32'd0);
          chk("disp_addr", 32'(bus.ram_addr), 32'(fa));
        end else if (prev_qn > 0) begin
          wr_t w;
          w = q.pop_front();
          chk("drain_we", 32'(bus.ram_we), 32'd1);
          chk("drain_addr", 32'(bus.ram_addr), 32'(w.addr));
          chk("drain_data", 32'(bus.ram_wdata), 32'(w.data));
        end else begin
          chk("idle_we", 32'(bus.ram_we), 32'd0);
          chk("idle_addr", 32'(bus.ram_addr), 32'(last_addr));
        end
        chk("level", 32'(fifo_level), 32'(q.size()));
        chk("ready", 32'(bus.wr_ready), 32'(q.size() < DEPTH));
        chk("oob", 32'(wr_oob), 32'(model_oob));
        if (steady >= 4) begin
          bit vis;
          vis = timing_en && hcount < HA && vcount < VA;
          chk("blank_n", 32'(px_blank_n), 32'(vis));
          chk("rgb", {8'd0, px_r, px_g, px_b},
              vis ? exp_rgb(int'(vcount) * HA + int'(hcount)) : 32'd0);
        end
      end
      if (bus.ram_we) wr_seen++;
      last_addr = bus.ram_addr;
      prev_qn   = q.size();
      if (since_rst >= 2 && bus.wr_valid && q.size() < DEPTH) begin
        if (bus.wr_x < HA && bus.wr_y < VA) begin
          wr_t w;
          w.addr = int'(bus.wr_y) * HA + int'(bus.wr_x);
          w.data = bus.wr_data;
          q.push_back(w);
          written[w.addr] = w.data;
        end else begin
          model_oob = 1'b1;
        end
      end
      prev_h = int'(hcount); prev_v = int'(vcount); prev_en = timing_en;
    end
  end

  task automatic nxt();
    @(posedge vga_clk); #1;
    if (hcount == 10'(HT - 1)) begin
      hcount = '0;
      vcount = (vcount == 10'(VT - 1)) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount = hcount + 10'd1;
    end
    steady++;
  endtask

  task automatic seek(int h, int v, bit en);
    @(posedge vga_clk); #1;
    hcount = 10'(h); vcount = 10'(v); timing_en = en; steady = 1;
  endtask

  task automatic run_to(int h, int v);
    int n = 0;
    while (!(hcount == 10'(h) && vcount == 10'(v)) && n < 5 * HT) begin nxt(); n++; end
    if (n >= 5 * HT) begin
      miscompares++;
      $display("FAIL run_to: position %0d,%0d not reached", h, v);
    end
  endtask

  task automatic drive_wr(int x, int y, logic [DW-1:0] d);
    bus.wr_valid = 1'b1; bus.wr_x = 10'(x); bus.wr_y = 9'(y); bus.wr_data = d;
  endtask

  initial begin
    int base, n;
    rst_n = 1'b0; timing_en = 1'b0; hcount = '0; vcount = '0;
    bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_we", 32'(bus.ram_we), 32'd0);
    chk("rst_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("rst_rgb", {8'd0, px_r, px_g, px_b}, 32'd0);
    chk("rst_blank_n", 32'(px_blank_n), 32'd0);
    chk("rst_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_oob", 32'(wr_oob), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    @(posedge vga_clk); #1 rst_n = 1'b1;
    @(posedge vga_clk); @(negedge vga_clk);
    chk("ready_after_rst", 32'(bus.wr_ready), 32'd1);

    // Preloaded display readout
    seek(790, 1, 1'b1);
    run_to(5, 2); @(negedge vga_clk);
    chk("px_5_2", {8'd0, px_r, px_g, px_b}, exp_rgb(1285));
    chk("px_5_2_vis", 32'(px_blank_n), 32'd1);
    run_to(640, 2); @(negedge vga_clk);
    chk("px_640_blank", 32'(px_blank_n), 32'd0);

    // Line and frame wrap prefetch
    seek(780, 10, 1'b1); run_to(797, 10); nxt(); @(negedge vga_clk);
    chk("wrap_addr", 32'(bus.ram_addr), 32'd7040);
    chk("wrap_we", 32'(bus.ram_we), 32'd0);
    seek(780, 524, 1'b1); run_to(797, 524); nxt(); @(negedge vga_clk);
    chk("frame_wrap_addr", 32'(bus.ram_addr), 32'd0);
    chk("frame_wrap_we", 32'(bus.ram_we), 32'd0);

    // Write during active region waits for the first non-display slot
    seek(90, 50, 1'b1); run_to(100, 50);
    drive_wr(3, 4, DW'(24'hABCDEF));
    nxt(); bus.wr_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge vga_clk);
      if (bus.ram_we || n >= 1000) break;
      nxt(); n++;
    end
    chk("act_wr_hcount", 32'(hcount), 32'd638);
    chk("act_wr_addr", 32'(bus.ram_addr), 32'd2563);
    chk("act_wr_data", 32'(bus.ram_wdata), 32'(DW'(24'hABCDEF)));

    // FIFO fills to depth inside the active region, drains in blanking
    seek(90, 60, 1'b1); run_to(100, 60);
    base = wr_seen;
    for (int i = 0; i < 10; i++) begin
      drive_wr($urandom_range(0, HA - 1), $urandom_range(100, 103), DW'($urandom));
      @(negedge vga_clk);
      chk("full_ready", 32'(bus.wr_ready), 32'(i < DEPTH));
      nxt();
    end
    bus.wr_valid = 1'b0; @(negedge vga_clk);
    chk("full_level", 32'(fifo_level), 32'(DEPTH));
    run_to(0, 61); @(negedge vga_clk);
    chk("drained_level", 32'(fifo_level), 32'd0);
    chk("drained_count", 32'(wr_seen - base), 32'(DEPTH));

    // Out-of-range write with display disabled (every cycle a write slot)
    seek(0, 0, 1'b0);
    drive_wr(640, 0, DW'(24'h123456));
    nxt(); bus.wr_valid = 1'b0; @(negedge vga_clk);
    chk("oob_flag", 32'(wr_oob), 32'd1);
    chk("oob_level", 32'(fifo_level), 32'd0);
    base = wr_seen;
    repeat (20) nxt();
    @(negedge vga_clk);
    chk("oob_no_write", 32'(wr_seen - base), 32'd0);
    chk("en0_blank", 32'(px_blank_n), 32'd0);

    // Random write traffic against a running display
    seek(0, 20, 1'b1);
    for (int i = 0; i < 400; i++) begin
      bus.wr_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.wr_x = 10'($urandom_range(0, 1023));
        bus.wr_y = 9'($urandom_range(480, 511));
      end else begin
        bus.wr_x = 10'($urandom_range(0, HA - 1));
        bus.wr_y = 9'($urandom_range(100, 103));
      end
      bus.wr_data = DW'($urandom);
      nxt();
    end
    bus.wr_valid = 1'b0;
    run_to(0, 22); @(negedge vga_clk);
    chk("rand_level", 32'(fifo_level), 32'd0);

    // Read back the written rows through the display path
    seek(790, 99, 1'b1); run_to(0, 104);

    // Reset while draining: queue is lost, no write after release
    seek(620, 70, 1'b1); run_to(625, 70);
    for (int i = 0; i < 5; i++) begin
      drive_wr($urandom_range(0, HA - 1), 200, DW'($urandom));
      nxt();
    end
    bus.wr_valid = 1'b0;
    run_to(638, 70); @(negedge vga_clk);
    chk("pre_rst_we", 32'(bus.ram_we), 32'd1);
    chk("pre_rst_level", 32'(fifo_level), 32'd4);
    #1 rst_n = 1'b0;
    q.delete(); model_oob = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bus.ram_we), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_ready", 32'(bus.wr_ready), 32'd0);
    chk("mid_rst_oob", 32'(wr_oob), 32'd0);
    repeat (2) @(posedge vga_clk);
    #1 rst_n = 1'b1;
    seek(0, 0, 1'b0);
    base = wr_seen;
    repeat (30) nxt();
    @(negedge vga_clk);
    chk("post_rst_no_write", 32'(wr_seen - base), 32'd0);
    chk("post_rst_level", 32'(fifo_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Shares one single-port synchronous framebuffer RAM between display scan-out and a pixel-write requester, all in the `vga_clk` domain. It sits between the VGA timing generator, which supplies the pixel and line counts, and the VGA output pins. Scan-out reads are scheduled a fixed lead ahead of the beam and always win the RAM. Writes are buffered in a small FIFO and drained only in cycles the display does not need.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixel cycles per line
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, lines per frame
- FIFO_DEPTH, 8, write FIFO entries (power of 2, ≥2)

Ports:
- vga_clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- timing_en  in  1  timing generator counting; 0 = no display fetches
- hcount_in  in  10  current pixel count, 0..H_TOTAL-1
- vcount_in  in  10  current line count, 0..V_TOTAL-1
- wr_valid  in  1  write request
- wr_ready  out  1  FIFO can accept
- wr_x  in  10  write column
- wr_y  in  9  write row
- wr_data  in  DW  pixel; DW=24 ({r,g,b}), or 1 when mono
- ram_addr  out  19  registered address, y*H_ACTIVE+x
- ram_we  out  1  registered write enable
- ram_wdata  out  DW  registered write data
- ram_rdata  in  DW  read data, valid 1 cycle after address sampled
- px_r, px_g, px_b  out  8 each  output pixel
- px_blank_n  out  1  1 = visible pixel
- wr_oob  out  1  sticky: out-of-range write dropped
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Fetch coordinate, computed each cycle:
  - fx = hcount_in + 3.
  - If fx ≥ H_TOTAL: fx -= H_TOTAL and fy = vcount_in + 1, with fy wrapping to 0 at V_TOTAL.
  - Otherwise fy = vcount_in.
- Display slot: timing_en && fx < H_ACTIVE && fy < V_ACTIVE. Next-cycle ram_addr = fy*H_ACTIVE+fx and ram_we = 0.
- Write slot: any non-display cycle with FIFO non-empty. Pop the head; next-cycle ram_addr, ram_we=1 and ram_wdata come from the head entry.
- Idle slot: ram_we = 0 and ram_addr holds its value.
- FIFO push: wr_valid && wr_ready.
  - An entry with wr_x ≥ H_ACTIVE or wr_y ≥ V_ACTIVE is accepted but not stored; it sets wr_oob.
  - wr_oob clears only on reset.
- wr_ready = !full. There is no pass-through when full, even if the FIFO pops in the same cycle.
- Simultaneous push and pop on a non-empty FIFO leaves the level unchanged.
- A write to a pixel whose display read is in flight is legal. The display shows old or new data depending on slot order; this is not a hazard.
- Blanking: a pixel outside the active area drives px_r/g/b = 0 and px_blank_n = 0.

## Timing
- 3-cycle pipeline:
  - Cycle t: compute the slot.
  - t+1: ram_addr registered.
  - t+2: ram_rdata valid.
  - t+3: px_* registered.
- The pixel for (x,y) is therefore on px_* during the cycle in which hcount_in==x and vcount_in==y.
- The first pixel of each line is fetched at hcount_in = H_TOTAL-3 of the preceding line. Line 0 is fetched from line V_TOTAL-1.
- Write drain latency: a pushed entry reaches ram_we no earlier than 2 cycles after acceptance.
- During the active region, write slots occur only for the last 3 cycles of the visible row window, then through horizontal blanking.
- Reset values:
  - ram_addr = 0, ram_we = 0, ram_wdata = 0.
  - px_r/g/b = 0, px_blank_n = 0.
  - wr_ready = 0 while rst_n is low, 1 from the first clock after release.
  - wr_oob = 0, fifo_level = 0.
- Reset mid-operation: the FIFO is flushed and pending writes are lost. The pipeline clears; no partial write is issued.
- timing_en = 0: every cycle is a write slot, and px_blank_n = 0 after pipeline drain.

## Configuration
- VGA_FB_MONO_EN defined:
  - DW = 1.
  - On output, px_r/g/b = 8'hFF if the pixel bit is 1, else 8'h00.
- Not defined:
  - DW = 24, with {r[23:16], g[15:8], b[7:0]} passed through unchanged.

## Test plan
- Reset and fill: preload the RAM with value = address, run one frame with timing_en=1. At hcount_in=5, vcount_in=2, px_* shows the address-1285 value and px_blank_n=1. At hcount_in=640, px_blank_n=0.
- Line-wrap prefetch: at hcount_in=797, vcount_in=10, the next cycle drives ram_addr=11*640=7040 with ram_we=0. At vcount_in=524 it fetches address 0.
- Write during active region: push (x=3,y=4,data=0xABCDEF) while hcount_in=100, vcount_in=50. ram_we must not assert until the first non-display slot (fx ≥ 640). ram_addr=2563 at that write.
- FIFO full: hold wr_valid for 10 pixels inside the active region with FIFO_DEPTH=8. wr_ready drops after 8 accepts and fifo_level=8. All 8 writes drain in order during blanking.
- Out-of-range write: push (x=640,y=0). wr_oob=1, fifo_level stays 0, and no ram_we is generated.
- Reset mid-drain: assert rst_n=0 with 5 entries queued. ram_we=0 immediately, fifo_level=0, and no writes occur after release.
